// File: rtl/frame_stream_host.sv
// Host-side stream endpoint: sends one frame of incrementing-byte words to
// the app's din port, takes the same number of words back from dout, and
// keeps counts, a wrapping checksum and a stall watchdog.
module frame_stream_host #(
  parameter int FRAME_WORDS = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [63:0] rx_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  // Watchdog only ever needs to hold values up to TIMEOUT-1.
  localparam int              WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [15:0]     FW      = 16'(FRAME_WORDS);
  localparam logic [63:0]     WORD0   = 64'h0706050403020100;

  state_t         state_q;
  logic [15:0]    tx_count_q, rx_count_q;
  logic [63:0]    tx_data_q, rx_sum_q;
  logic [WDW-1:0] wd_q;
  logic           busy_q, done_q, error_q;

  logic           tx_hs, rx_hs;
  logic [15:0]    tx_count_d, rx_count_d;
  logic [WDW-1:0] wd_inc;
  logic [63:0]    tx_word_d;

  // Valid/ready depend on state and counts only, never on the far side.
  assign tx_valid   = (state_q == RUN) && (tx_count_q < FW);
  assign rx_ready   = (state_q == RUN) && (rx_count_q < FW);
  assign tx_hs      = tx_valid & tx_ready;
  assign rx_hs      = rx_valid & rx_ready;
  assign tx_count_d = tx_count_q + 16'(tx_hs);
  assign rx_count_d = rx_count_q + 16'(rx_hs);
  assign wd_inc     = wd_q + WDW'(1);

  // Next test word: every byte steps by 8, wrapping within the byte.
  always_comb begin
    tx_word_d = '0;
    for (int j = 0; j < 8; j++) tx_word_d[8*j +: 8] = tx_data_q[8*j +: 8] + 8'd8;
  end

  // Frame FSM with registered status outputs, counters, checksum and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_count_q <= '0;
      rx_count_q <= '0;
      tx_data_q  <= '0;
      rx_sum_q   <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q    <= RUN;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_data_q  <= WORD0;
            rx_sum_q   <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        RUN: begin
          if (tx_hs) begin
            tx_count_q <= tx_count_d;
            tx_data_q  <= tx_word_d;
          end
          if (rx_hs) begin
            rx_count_q <= rx_count_d;
            rx_sum_q   <= rx_sum_q + rx_data;
          end
          wd_q <= (tx_hs || rx_hs) ? '0 : wd_inc;
          // Completion wins over a timeout landing in the same cycle.
          if (tx_count_d == FW && rx_count_d == FW) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!(tx_hs || rx_hs) && wd_inc == WD_LAST) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign tx_data  = tx_data_q;
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign rx_sum   = rx_sum_q;
endmodule
